// File: rtl/pcie_lane_tx_scrambler.sv
// Per-lane transmit scramble stage: drives the lane LFSR codec and XORs
// data symbols with its mask, registering the result toward the 8b10b encoder.
module pcie_lane_tx_scrambler #(
    parameter logic [7:0]  COM_SYM  = 8'hBC,
    parameter logic [7:0]  SKP_SYM  = 8'h1C,
    parameter int          TS_LEN   = 16,
    parameter logic [15:0] SCR_INIT = 16'hFFFF
) (
    input  logic        ClkPci,
    input  logic        ResetPci,
    input  logic        ScrDisable,
    input  logic [7:0]  InData,
    input  logic        InK,
    input  logic        InTsOs,
    input  logic        InValid,
    output logic        InReady,
    output logic [7:0]  OutData,
    output logic        OutK,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [15:0] ScrShift,
    output logic        ScrMovePipe,
    input  logic [15:0] ScrOutShift,
    output logic        TsActive
);

    localparam int TW = $clog2(TS_LEN);
    localparam logic [TW-1:0] TS_LAST = TW'(TS_LEN - 1);

    logic [TW-1:0] tsCnt;
    logic [TW-1:0] tsCntNext;
    logic          accept;
    logic          isCom;
    logic          isSkp;
    logic          scramble;
    logic [7:0]    mask;
    logic [7:0]    dataNext;

    assign InReady  = ~ResetPci & (~OutValid | OutReady);
    assign accept   = InValid & InReady;
    assign isCom    = InK & (InData == COM_SYM);
    assign isSkp    = InK & (InData == SKP_SYM);
    assign TsActive = (tsCnt != '0);

    // Mask bit 0 is the bit the serial LFSR would emit first.
    assign mask = {ScrOutShift[8],  ScrOutShift[9],
                   ScrOutShift[10], ScrOutShift[11],
                   ScrOutShift[12], ScrOutShift[13],
                   ScrOutShift[14], ScrOutShift[15]};

    assign scramble = ~InK & ~ScrDisable & ~TsActive;
    assign dataNext = scramble ? (InData ^ mask) : InData;

    always_comb begin
        ScrShift    = ScrOutShift;
        ScrMovePipe = 1'b0;
        if (ResetPci) begin
            ScrShift = SCR_INIT;
        end else if (accept) begin
            if (isCom) begin
                ScrShift = SCR_INIT;
            end else if (!isSkp) begin
                ScrMovePipe = 1'b1;
            end
        end
    end

    always_comb begin
        tsCntNext = tsCnt;
        if (accept) begin
            if (isCom) begin
                tsCntNext = InTsOs ? TS_LAST : '0;
            end else if (!isSkp && TsActive) begin
                tsCntNext = tsCnt - 1'b1;
            end
        end
    end

    always_ff @(posedge ClkPci or posedge ResetPci) begin
        if (ResetPci) begin
            OutValid <= 1'b0;
            OutData  <= 8'h00;
            OutK     <= 1'b0;
            tsCnt    <= '0;
        end else begin
            tsCnt <= tsCntNext;
            if (accept) begin
                OutValid <= 1'b1;
                OutData  <= dataNext;
                OutK     <= InK;
            end else if (OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pcie_lane_tx_scrambler.sv
// Directed bench for pcie_lane_tx_scrambler with a behavioural lane LFSR
// codec (x^16+x^5+x^4+x^3+1, 8 serial steps per advance).
module tb_pcie_lane_tx_scrambler;

    logic        ClkPci = 1'b0;
    logic        ResetPci;
    logic        ScrDisable;
    logic [7:0]  InData;
    logic        InK;
    logic        InTsOs;
    logic        InValid;
    logic        InReady;
    logic [7:0]  OutData;
    logic        OutK;
    logic        OutValid;
    logic        OutReady;
    logic [15:0] ScrShift;
    logic        ScrMovePipe;
    logic [15:0] ScrOutShift;
    logic        TsActive;

    int nChecks = 0;
    int nPass   = 0;

    pcie_lane_tx_scrambler dut (
        .ClkPci      (ClkPci),
        .ResetPci    (ResetPci),
        .ScrDisable  (ScrDisable),
        .InData      (InData),
        .InK         (InK),
        .InTsOs      (InTsOs),
        .InValid     (InValid),
        .InReady     (InReady),
        .OutData     (OutData),
        .OutK        (OutK),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .ScrShift    (ScrShift),
        .ScrMovePipe (ScrMovePipe),
        .ScrOutShift (ScrOutShift),
        .TsActive    (TsActive)
    );

    always #5 ClkPci = ~ClkPci;

    function automatic logic [15:0] adv8(input logic [15:0] s);
        logic [15:0] t;
        logic        fb;
        t = s;
        for (int i = 0; i < 8; i++) begin
            fb = t[15];
            t  = {t[14:0], 1'b0};
            if (fb) t = t ^ 16'h0039;
        end
        return t;
    endfunction

    // Lane codec: reset seeds it, otherwise it loads Shift (advanced on MovePipe).
    always @(posedge ClkPci or posedge ResetPci) begin
        if (ResetPci)
            ScrOutShift <= 16'hFFFF;
        else if (ScrMovePipe)
            ScrOutShift <= adv8(ScrShift);
        else
            ScrOutShift <= ScrShift;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nChecks++;
        if (got === exp)
            nPass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic xfer(input string tag, input logic [7:0] d,
                        input logic k, input logic ts,
                        input logic [7:0] expD, input logic expMove);
        @(negedge ClkPci);
        InData  = d;
        InK     = k;
        InTsOs  = ts;
        InValid = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(InReady), 32'd1);
        chk({tag, ".move"}, 32'(ScrMovePipe), 32'(expMove));
        if (k && d == 8'hBC)
            chk({tag, ".shift"}, 32'(ScrShift), 32'hFFFF);
        @(posedge ClkPci);
        #1;
        chk({tag, ".vld"}, 32'(OutValid), 32'd1);
        chk({tag, ".data"}, 32'(OutData), 32'(expD));
        chk({tag, ".k"}, 32'(OutK), 32'(k));
        InValid = 1'b0;
    endtask

    task automatic doReset();
        @(negedge ClkPci);
        ResetPci = 1'b1;
        #1;
        chk("rst.vld", 32'(OutValid), 32'd0);
        chk("rst.data", 32'(OutData), 32'h00);
        chk("rst.rdy", 32'(InReady), 32'd0);
        chk("rst.shift", 32'(ScrShift), 32'hFFFF);
        chk("rst.move", 32'(ScrMovePipe), 32'd0);
        chk("rst.ts", 32'(TsActive), 32'd0);
        @(negedge ClkPci);
        ResetPci = 1'b0;
    endtask

    initial begin
        ResetPci   = 1'b1;
        ScrDisable = 1'b0;
        InData     = 8'h00;
        InK        = 1'b0;
        InTsOs     = 1'b0;
        InValid    = 1'b0;
        OutReady   = 1'b1;
        repeat (2) @(posedge ClkPci);
        doReset();

        // 1: basic scrambling from seed
        xfer("t1.com", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t1.d0",  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
        xfer("t1.d1",  8'h00, 1'b0, 1'b0, 8'h17, 1'b1);
        xfer("t1.d2",  8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);
        @(posedge ClkPci);
        #1;
        chk("t1.idle", 32'(OutValid), 32'd0);

        // 2: SKP holds LFSR
        xfer("t2.com",  8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t2.skp0", 8'h1C, 1'b1, 1'b0, 8'h1C, 1'b0);
        xfer("t2.skp1", 8'h1C, 1'b1, 1'b0, 8'h1C, 1'b0);
        xfer("t2.d0",   8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
        xfer("t2.d1",   8'h00, 1'b0, 1'b0, 8'h17, 1'b1);

        // 3: training set leaves its 15 symbols unscrambled
        xfer("t3.com", 8'hBC, 1'b1, 1'b1, 8'hBC, 1'b0);
        chk("t3.act", 32'(TsActive), 32'd1);
        for (int i = 0; i < 15; i++) begin
            xfer($sformatf("t3.ts%0d", i), 8'h4A, 1'b0, 1'b0, 8'h4A, 1'b1);
            chk($sformatf("t3.act%0d", i), 32'(TsActive),
                (i == 14) ? 32'd0 : 32'd1);
        end
        xfer("t3.com2", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t3.d0",   8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);

        // 4: disable passes data but LFSR keeps stepping
        ScrDisable = 1'b1;
        xfer("t4.com", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t4.d0",  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        xfer("t4.d1",  8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
        ScrDisable = 1'b0;
        xfer("t4.d2",  8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);

        // 5: output stall freezes everything
        xfer("t5.com", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t5.d0",  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge ClkPci);
            OutReady = 1'b0;
            InData   = 8'h00;
            InK      = 1'b0;
            InValid  = 1'b1;
            #1;
            chk($sformatf("t5.rdy%0d", i), 32'(InReady), 32'd0);
            chk($sformatf("t5.move%0d", i), 32'(ScrMovePipe), 32'd0);
            @(posedge ClkPci);
            #1;
            chk($sformatf("t5.vld%0d", i), 32'(OutValid), 32'd1);
            chk($sformatf("t5.hold%0d", i), 32'(OutData), 32'hFF);
        end
        @(negedge ClkPci);
        OutReady = 1'b1;
        #1;
        chk("t5.rel.rdy", 32'(InReady), 32'd1);
        chk("t5.rel.move", 32'(ScrMovePipe), 32'd1);
        @(posedge ClkPci);
        #1;
        chk("t5.rel.data", 32'(OutData), 32'h17);
        InValid = 1'b0;
        xfer("t5.d2", 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1);

        // 6: asynchronous reset mid-stream
        xfer("t6.com", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t6.d0",  8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);
        xfer("t6.d1",  8'h00, 1'b0, 1'b0, 8'h17, 1'b1);
        doReset();
        xfer("t6.com2", 8'hBC, 1'b1, 1'b0, 8'hBC, 1'b0);
        xfer("t6.d2",   8'h00, 1'b0, 1'b0, 8'hFF, 1'b1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
